// File: rtl/mvb_merge_arbiter.sv
// mvb_merge_arbiter: shares one registered MVB output between two MVB producers.
// Word-granularity round-robin with a burst quantum. Every output word carries
// the index of the input it came from. Empty words (no item valid) are consumed
// and dropped without touching the output register or the arbitration state.
module mvb_merge_arbiter #(
    parameter int ITEMS      = 4,
    parameter int ITEM_WIDTH = 32,
    parameter int BURST      = 4
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [ITEMS*ITEM_WIDTH-1:0] RX0_DATA,
    input  logic [ITEMS-1:0]            RX0_VLD,
    input  logic                        RX0_SRC_RDY,
    output logic                        RX0_DST_RDY,
    input  logic [ITEMS*ITEM_WIDTH-1:0] RX1_DATA,
    input  logic [ITEMS-1:0]            RX1_VLD,
    input  logic                        RX1_SRC_RDY,
    output logic                        RX1_DST_RDY,
    output logic [ITEMS*ITEM_WIDTH-1:0] TX_DATA,
    output logic [ITEMS-1:0]            TX_VLD,
    output logic                        TX_SRC,
    output logic                        TX_SRC_RDY,
    input  logic                        TX_DST_RDY
);

    localparam int DW = ITEMS * ITEM_WIDTH;
    // Burst limit widened to 9 bits so BURST=256 compares against CNT+1 exactly.
    localparam logic [8:0] BURST_W = 9'(BURST);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             full_q, full_d;
    logic [DW-1:0]    data_q, data_d;
    logic [ITEMS-1:0] vld_q, vld_d;
    logic             src_q, src_d;

    logic             gnt, gnt_vld, can_load, go, counted, other_rdy;
    logic [DW-1:0]    sel_data;
    logic [ITEMS-1:0] sel_vld;

    // Grant: an active lock wins if its input still presents; otherwise the
    // pointer breaks ties and a lone requester is served directly.
    always_comb begin
        gnt     = 1'b0;
        gnt_vld = 1'b1;
        if (state_q == LOCK0 && RX0_SRC_RDY)      gnt = 1'b0;
        else if (state_q == LOCK1 && RX1_SRC_RDY) gnt = 1'b1;
        else if (RX0_SRC_RDY && RX1_SRC_RDY)      gnt = ptr_q;
        else if (RX0_SRC_RDY)                     gnt = 1'b0;
        else if (RX1_SRC_RDY)                     gnt = 1'b1;
        else                                      gnt_vld = 1'b0;
    end

    // The output register can take a word when empty or draining this cycle.
    // RESET gating keeps both DST_RDY low for the whole reset window.
    assign can_load    = !full_q || TX_DST_RDY;
    assign go          = gnt_vld && can_load && RESET;
    assign RX0_DST_RDY = go && !gnt;
    assign RX1_DST_RDY = go && gnt;

    assign sel_data  = gnt ? RX1_DATA : RX0_DATA;
    assign sel_vld   = gnt ? RX1_VLD  : RX0_VLD;
    assign other_rdy = gnt ? RX0_SRC_RDY : RX1_SRC_RDY;
    assign counted   = go && (sel_vld != '0);

    // Next state: load on a counted accept, drain otherwise, and update the
    // burst lock. A lock whose owner went quiet is dropped in the same cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        data_d  = data_q;
        vld_d   = vld_q;
        src_d   = src_q;
        if (counted) begin
            data_d = sel_data;
            vld_d  = sel_vld;
            src_d  = gnt;
            full_d = 1'b1;
            if (({1'b0, cnt_q} + 9'd1 == BURST_W) || !other_rdy) begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                ptr_d   = ~gnt;
            end else begin
                state_d = gnt ? LOCK1 : LOCK0;
                cnt_d   = cnt_q + 8'd1;
            end
        end else begin
            if (full_q && TX_DST_RDY) full_d = 1'b0;
            if ((state_q == LOCK0 && !RX0_SRC_RDY) ||
                (state_q == LOCK1 && !RX1_SRC_RDY)) begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        end
    end

    // State and output register; reset discards any word in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= 8'd0;
            full_q  <= 1'b0;
            data_q  <= '0;
            vld_q   <= '0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            src_q   <= src_d;
        end
    end

    assign TX_DATA    = data_q;
    assign TX_VLD     = vld_q;
    assign TX_SRC     = src_q;
    assign TX_SRC_RDY = full_q;

endmodule

// File: tb/tb_mvb_merge_arbiter.sv
// Bench for mvb_merge_arbiter: directed phases feed per-input word queues;
// a monitor pops expected words per source and an expected source order.
// A second instance with BURST=1 and constant inputs checks strict alternation.
module tb_mvb_merge_arbiter;

    localparam int IT = 4;
    localparam int IW = 32;
    localparam int DW = IT * IW;

    typedef struct {
        logic [DW-1:0] data;
        logic [IT-1:0] vld;
    } word_t;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [DW-1:0] RX0_DATA, RX1_DATA, TX_DATA;
    logic [IT-1:0] RX0_VLD, RX1_VLD, TX_VLD;
    logic          RX0_SRC_RDY, RX1_SRC_RDY, RX0_DST_RDY, RX1_DST_RDY;
    logic          TX_SRC, TX_SRC_RDY, TX_DST_RDY;

    logic [DW-1:0] d1_rx0_data, d1_rx1_data, d1_tx_data;
    logic [IT-1:0] d1_rx0_vld, d1_rx1_vld, d1_tx_vld;
    logic          d1_rx0_src, d1_rx1_src, d1_rx0_dst, d1_rx1_dst;
    logic          d1_tx_src, d1_tx_src_rdy, d1_tx_dst_rdy;

    word_t pend0[$], pend1[$], exp0[$], exp1[$];
    logic  src_exp[$];
    int    checks = 0;
    int    errors = 0;
    int    chk1_n = 8;
    logic  t1 = 1'b0;

    always #5 CLK = ~CLK;

    mvb_merge_arbiter #(.ITEMS(IT), .ITEM_WIDTH(IW), .BURST(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .RX0_DATA(RX0_DATA), .RX0_VLD(RX0_VLD), .RX0_SRC_RDY(RX0_SRC_RDY), .RX0_DST_RDY(RX0_DST_RDY),
        .RX1_DATA(RX1_DATA), .RX1_VLD(RX1_VLD), .RX1_SRC_RDY(RX1_SRC_RDY), .RX1_DST_RDY(RX1_DST_RDY),
        .TX_DATA(TX_DATA), .TX_VLD(TX_VLD), .TX_SRC(TX_SRC),
        .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY)
    );

    mvb_merge_arbiter #(.ITEMS(IT), .ITEM_WIDTH(IW), .BURST(1)) dut1 (
        .CLK(CLK), .RESET(RESET),
        .RX0_DATA(d1_rx0_data), .RX0_VLD(d1_rx0_vld), .RX0_SRC_RDY(d1_rx0_src), .RX0_DST_RDY(d1_rx0_dst),
        .RX1_DATA(d1_rx1_data), .RX1_VLD(d1_rx1_vld), .RX1_SRC_RDY(d1_rx1_src), .RX1_DST_RDY(d1_rx1_dst),
        .TX_DATA(d1_tx_data), .TX_VLD(d1_tx_vld), .TX_SRC(d1_tx_src),
        .TX_SRC_RDY(d1_tx_src_rdy), .TX_DST_RDY(d1_tx_dst_rdy)
    );

    function automatic logic [DW-1:0] mkdata(input logic s, input int idx);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < IT; k++) d[k*IW +: IW] = {4'hA, 3'b000, s, 8'(idx), 8'(k), 8'h5A};
        return d;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic send(input logic s, input logic [DW-1:0] d, input logic [IT-1:0] v);
        word_t w;
        w.data = d;
        w.vld  = v;
        if (!s) begin
            pend0.push_back(w);
            if (v != '0) exp0.push_back(w);
        end else begin
            pend1.push_back(w);
            if (v != '0) exp1.push_back(w);
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        @(negedge CLK);
        while ((pend0.size() + pend1.size() + exp0.size() + exp1.size() + src_exp.size() != 0
                || TX_SRC_RDY) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_drain actual=timeout required=all words delivered", nm);
        end
    endtask

    // Source driver: presents queue heads after each falling edge, pops on handshake.
    initial begin
        RX0_SRC_RDY = 1'b0; RX0_DATA = '0; RX0_VLD = '0;
        RX1_SRC_RDY = 1'b0; RX1_DATA = '0; RX1_VLD = '0;
        forever begin
            @(negedge CLK);
            #1;
            if (pend0.size() > 0) begin
                RX0_SRC_RDY = 1'b1; RX0_DATA = pend0[0].data; RX0_VLD = pend0[0].vld;
            end else begin
                RX0_SRC_RDY = 1'b0; RX0_DATA = '0; RX0_VLD = '0;
            end
            if (pend1.size() > 0) begin
                RX1_SRC_RDY = 1'b1; RX1_DATA = pend1[0].data; RX1_VLD = pend1[0].vld;
            end else begin
                RX1_SRC_RDY = 1'b0; RX1_DATA = '0; RX1_VLD = '0;
            end
            #3;
            if (RX0_SRC_RDY && RX0_DST_RDY && pend0.size() > 0) void'(pend0.pop_front());
            if (RX1_SRC_RDY && RX1_DST_RDY && pend1.size() > 0) void'(pend1.pop_front());
        end
    end

    // Output monitor: per-source order, payload, and expected source sequence.
    initial begin
        word_t w;
        logic  s;
        forever begin
            @(negedge CLK);
            #4;
            if (RESET && TX_SRC_RDY && TX_DST_RDY) begin
                chk("tx_vld_nonzero", DW'(TX_VLD != '0), DW'(1));
                if (TX_SRC ? (exp1.size() == 0) : (exp0.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected actual=%0h src=%0d required=no word", TX_DATA, TX_SRC);
                end else begin
                    w = TX_SRC ? exp1.pop_front() : exp0.pop_front();
                    chk("tx_data", TX_DATA, w.data);
                    chk("tx_vld", DW'(TX_VLD), DW'(w.vld));
                end
                if (src_exp.size() > 0) begin
                    s = src_exp.pop_front();
                    chk("tx_src_order", DW'(TX_SRC), DW'(s));
                end
            end
        end
    end

    // BURST=1 instance: both inputs always ready, so sources must alternate 0,1,0,...
    initial begin
        forever begin
            @(negedge CLK);
            #4;
            if (RESET && chk1_n > 0) begin
                chk("d1_one_grant", DW'(d1_rx0_dst ^ d1_rx1_dst), DW'(1));
                if (d1_tx_src_rdy) begin
                    chk("d1_src_alt", DW'(d1_tx_src), DW'(t1));
                    chk("d1_data", d1_tx_data, mkdata(t1, 0));
                    chk("d1_vld", DW'(d1_tx_vld), DW'(4'hF));
                    t1 = ~t1;
                    chk1_n--;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Directed phases.
    initial begin
        RESET = 1'b0;
        TX_DST_RDY = 1'b1;
        d1_rx0_data = mkdata(1'b0, 0); d1_rx0_vld = 4'hF; d1_rx0_src = 1'b1;
        d1_rx1_data = mkdata(1'b1, 0); d1_rx1_vld = 4'hF; d1_rx1_src = 1'b1;
        d1_tx_dst_rdy = 1'b1;

        // Contention from reset release, BURST=4: 0x4,1x4 repeated.
        for (int j = 0; j < 12; j++) begin
            send(1'b0, mkdata(1'b0, j), 4'hF);
            send(1'b1, mkdata(1'b1, j), 4'hF);
        end
        for (int b = 0; b < 6; b++)
            for (int j = 0; j < 4; j++) src_exp.push_back(1'(b % 2));
        repeat (2) @(negedge CLK);
        #3;
        chk("rst_tx_src_rdy", DW'(TX_SRC_RDY), DW'(0));
        chk("rst_tx_vld", DW'(TX_VLD), DW'(0));
        chk("rst_tx_data", TX_DATA, DW'(0));
        chk("rst_tx_src", DW'(TX_SRC), DW'(0));
        chk("rst_rx0_dst_rdy", DW'(RX0_DST_RDY), DW'(0));
        chk("rst_rx1_dst_rdy", DW'(RX1_DST_RDY), DW'(0));
        @(negedge CLK);
        RESET = 1'b1;
        drain("burst4");
        chk("d1_alternation_done", DW'(chk1_n), DW'(0));

        // RX0 stops after 2 words of its burst: RX1 takes over with no gap.
        send(1'b0, mkdata(1'b0, 20), 4'hF);
        send(1'b0, mkdata(1'b0, 21), 4'hF);
        for (int j = 22; j < 26; j++) send(1'b1, mkdata(1'b1, j), 4'hF);
        src_exp.push_back(1'b0); src_exp.push_back(1'b0);
        for (int j = 0; j < 4; j++) src_exp.push_back(1'b1);
        #3;
        chk("p3_c0_rx0_dst", DW'(RX0_DST_RDY), DW'(1));
        chk("p3_c0_rx1_dst", DW'(RX1_DST_RDY), DW'(0));
        @(negedge CLK); #3;
        chk("p3_c1_lock_rx0", DW'(RX0_DST_RDY), DW'(1));
        chk("p3_c1_rx1_dst", DW'(RX1_DST_RDY), DW'(0));
        chk("p3_c1_tx", DW'(TX_SRC_RDY), DW'(1));
        @(negedge CLK); #3;
        chk("p3_c2_rx1_takeover", DW'(RX1_DST_RDY), DW'(1));
        chk("p3_c2_tx", DW'(TX_SRC_RDY), DW'(1));
        for (int c = 3; c <= 6; c++) begin
            @(negedge CLK); #3;
            chk("p3_no_gap", DW'(TX_SRC_RDY), DW'(1));
        end
        drain("p3a");
        send(1'b0, mkdata(1'b0, 26), 4'hF);
        send(1'b1, mkdata(1'b1, 27), 4'hF);
        src_exp.push_back(1'b0); src_exp.push_back(1'b1);
        #3;
        chk("p3_ptr0_rx0_wins", DW'(RX0_DST_RDY), DW'(1));
        chk("p3_ptr0_rx1_waits", DW'(RX1_DST_RDY), DW'(0));
        drain("p3b");

        // Only RX0: 10 words back to back, one cycle latency.
        for (int j = 30; j < 40; j++) begin
            send(1'b0, mkdata(1'b0, j), 4'hF);
            src_exp.push_back(1'b0);
        end
        for (int k = 0; k < 12; k++) begin
            #3;
            if (k == 0) begin
                chk("p1_rx0_dst", DW'(RX0_DST_RDY), DW'(1));
                chk("p1_tx_empty_before", DW'(TX_SRC_RDY), DW'(0));
            end else if (k <= 10) begin
                chk("p1_no_gap", DW'(TX_SRC_RDY), DW'(1));
            end else begin
                chk("p1_tx_done", DW'(TX_SRC_RDY), DW'(0));
            end
            chk("p1_rx1_dst_low", DW'(RX1_DST_RDY), DW'(0));
            @(negedge CLK);
        end
        drain("p1");

        // RX1 interleaves empty words with 0101 words.
        send(1'b1, mkdata(1'b1, 40), 4'b0101);
        send(1'b1, mkdata(1'b1, 41), 4'b0000);
        send(1'b1, mkdata(1'b1, 42), 4'b0101);
        send(1'b1, mkdata(1'b1, 43), 4'b0000);
        send(1'b1, mkdata(1'b1, 44), 4'b0101);
        for (int j = 0; j < 3; j++) src_exp.push_back(1'b1);
        for (int k = 0; k < 5; k++) begin
            #3;
            chk("p4_rx1_dst_rdy", DW'(RX1_DST_RDY), DW'(1));
            if (k == 2) chk("p4_empty_not_shown", DW'(TX_SRC_RDY), DW'(0));
            @(negedge CLK);
        end
        drain("p4");

        // Backpressure for 5 cycles with both inputs ready.
        TX_DST_RDY = 1'b0;
        for (int j = 0; j < 6; j++) begin
            send(1'b0, mkdata(1'b0, 50 + j), 4'hF);
            send(1'b1, mkdata(1'b1, 60 + j), 4'hF);
        end
        for (int j = 0; j < 4; j++) src_exp.push_back(1'b0);
        for (int j = 0; j < 4; j++) src_exp.push_back(1'b1);
        src_exp.push_back(1'b0); src_exp.push_back(1'b0);
        src_exp.push_back(1'b1); src_exp.push_back(1'b1);
        #3;
        chk("p5_c0_rx0_dst", DW'(RX0_DST_RDY), DW'(1));
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK); #3;
            chk("p5_hold_rx0_dst", DW'(RX0_DST_RDY), DW'(0));
            chk("p5_hold_rx1_dst", DW'(RX1_DST_RDY), DW'(0));
            chk("p5_hold_tx_rdy", DW'(TX_SRC_RDY), DW'(1));
            chk("p5_hold_tx_data", TX_DATA, mkdata(1'b0, 50));
            chk("p5_hold_tx_src", DW'(TX_SRC), DW'(0));
        end
        @(negedge CLK);
        TX_DST_RDY = 1'b1;
        for (int c = 6; c <= 16; c++) begin
            #3;
            chk("p5_resume_no_gap", DW'(TX_SRC_RDY), DW'(1));
            @(negedge CLK);
        end
        drain("p5");

        // Reset while holding a word in LOCK1.
        for (int j = 0; j < 6; j++) send(1'b0, mkdata(1'b0, 70 + j), 4'hF);
        for (int j = 0; j < 3; j++) send(1'b1, mkdata(1'b1, 80 + j), 4'hF);
        repeat (5) @(negedge CLK);
        #1;
        chk("p6_pre_full", DW'(TX_SRC_RDY), DW'(1));
        chk("p6_pre_src1", DW'(TX_SRC), DW'(1));
        #1;
        RESET = 1'b0;
        #1;
        chk("p6_async_tx_src_rdy", DW'(TX_SRC_RDY), DW'(0));
        chk("p6_async_tx_vld", DW'(TX_VLD), DW'(0));
        chk("p6_async_tx_data", TX_DATA, DW'(0));
        chk("p6_async_tx_src", DW'(TX_SRC), DW'(0));
        chk("p6_rst_rx0_dst", DW'(RX0_DST_RDY), DW'(0));
        chk("p6_rst_rx1_dst", DW'(RX1_DST_RDY), DW'(0));
        pend0.delete(); pend1.delete(); exp0.delete(); exp1.delete(); src_exp.delete();
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        send(1'b0, mkdata(1'b0, 90), 4'hF);
        send(1'b1, mkdata(1'b1, 91), 4'hF);
        src_exp.push_back(1'b0); src_exp.push_back(1'b1);
        #3;
        chk("p6_post_rst_rx0_first", DW'(RX0_DST_RDY), DW'(1));
        chk("p6_post_rst_rx1_waits", DW'(RX1_DST_RDY), DW'(0));
        drain("p6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mvb_merge_arbiter.md
# mvb_merge_arbiter

Two-input MVB arbiter that shares a single MVB output bus between two MVB producers with word-granularity round-robin and a configurable burst quantum. It sits upstream of MVB item-merging and other single-consumer MVB datapaths, where two independent sources feed one resource. It tags every output word with its source index. The output is registered with full throughput.

## Interface
Parameters:
- ITEMS, 4, items per MVB word on all ports.
- ITEM_WIDTH, 32, bits per item.
- BURST, 4, maximum consecutive accepted words granted to one input while the other is waiting; legal range 1..256.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- RX0_DATA  in  ITEMS*ITEM_WIDTH  input 0 item data; item i in bits [(i+1)*ITEM_WIDTH-1 : i*ITEM_WIDTH].
- RX0_VLD  in  ITEMS  input 0 per-item valid.
- RX0_SRC_RDY  in  1  input 0 word present.
- RX0_DST_RDY  out  1  input 0 word accepted this cycle when high together with RX0_SRC_RDY.
- RX1_DATA, RX1_VLD, RX1_SRC_RDY, RX1_DST_RDY: same as RX0, for input 1.
- TX_DATA  out  ITEMS*ITEM_WIDTH  output item data.
- TX_VLD  out  ITEMS  output per-item valid.
- TX_SRC  out  1  index of the input the current TX word came from.
- TX_SRC_RDY  out  1  output word present.
- TX_DST_RDY  in  1  consumer accepts the TX word.

## Operation
- Output register OREG holds DATA, VLD, SRC and a full flag. TX_SRC_RDY = full.
- can_load = !full || TX_DST_RDY.
- State register: IDLE, LOCK0 or LOCK1.
- Priority pointer PTR: 1 bit, points to the input favoured on contention.
- Burst counter CNT: 8 bits.
- Grant gnt is combinational:
  - In LOCKx with RXx_SRC_RDY=1, gnt = x.
  - Otherwise, if both SRC_RDY are high, gnt = PTR.
  - Otherwise gnt is the single input with SRC_RDY high.
  - If neither SRC_RDY is high, there is no grant.
- RXg_DST_RDY = (g == gnt) && can_load.
  - The non-granted input's DST_RDY is 0.
  - DST_RDY never depends on the same input's SRC_RDY except through gnt.
- Accept occurs when the granted input has SRC_RDY=1 and can_load=1.
- Accept of a word with VLD != 0:
  - OREG loads DATA/VLD, SRC = gnt, and full is set to 1.
  - The word counts toward the burst.
- Accept of an empty word (SRC_RDY=1, VLD all 0):
  - The word is consumed and dropped.
  - OREG is not loaded, CNT and state are unchanged, and TX never shows a word with VLD=0.
- If full=1, TX_DST_RDY=1 and there is no load, full clears.
- Burst accounting applies on counted accepts from input g:
  - If CNT+1 == BURST, or the other input has SRC_RDY=0 at that moment: state goes to IDLE, CNT = 0, PTR = !g. With BURST=1 this is strict alternation under contention.
  - Otherwise: state goes to LOCKg, CNT = CNT+1.
- In LOCKx with RXx_SRC_RDY=0, the lock is released in the same cycle:
  - Grant follows the IDLE rules.
  - The next state is IDLE, or a new lock if the other input is accepted.
  - CNT restarts from the new accept.
- Data ordering per input is preserved. No word is duplicated or lost, except empty words, which are dropped by design.

## Timing
- Latency: a word accepted in cycle n is on TX from cycle n+1.
- Throughput: one word per cycle sustained when TX_DST_RDY=1.
- Backpressure: with full=1 and TX_DST_RDY=0, both RX DST_RDY are 0. TX_DATA, TX_VLD and TX_SRC hold stable until accepted.
- Reset values, applied asynchronously on RESET=0:
  - State IDLE, PTR 0, CNT 0, full 0.
  - TX_SRC_RDY 0, TX_VLD 0, TX_DATA 0, TX_SRC 0.
  - RX0_DST_RDY and RX1_DST_RDY: 0 while RESET=0.
- Reset mid-transfer: the OREG word is discarded. The first cycle after release behaves as from IDLE with PTR 0.
- Simultaneous accept and unload in the same cycle keeps full=1 with the new word. This is not a bubble.

## Test plan
- Only RX0 active, 10 words with VLD=1111 and TX_DST_RDY=1 -> 10 TX words in order, TX_SRC=0. First word appears one cycle after RX0 accept. No gaps. RX1_DST_RDY stays 0.
- Both inputs continuously ready, BURST=4, TX_DST_RDY=1 -> TX_SRC sequence 0,0,0,0,1,1,1,1,0,... Repeat with BURST=1 -> 0,1,0,1,...
- Contention, then RX0 drops SRC_RDY after 2 words of its burst -> RX1 is granted in the same cycle, with no idle cycle on TX. Afterwards RX0 wins the next contention, since PTR=0.
- RX1 sends words with VLD=0000 interleaved with VLD=0101 -> only the 0101 words appear on TX. Empty words are consumed: RX1_DST_RDY is high for them.
- TX_DST_RDY held 0 for 5 cycles with both inputs ready -> TX word stable and both DST_RDY low. On release, one word per cycle resumes and no data is lost (scoreboard per-input order).
- RESET asserted low while full=1 and in LOCK1 -> TX_SRC_RDY drops immediately, without waiting for CLK. After release, contention grants RX0 first.
